// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte stream in, instruction memory write port out
interface prog_loader_if #(
    parameter int AWIDTH = 8
) ();
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              o_wr;
    logic [AWIDTH-1:0] o_waddr;
    logic [15:0]       o_wdata;

    // Loader side: consumes bytes, drives the memory write port
    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output o_wr,
        output o_waddr,
        output o_wdata
    );

    // Byte source and instruction memory side
    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  o_wr,
        input  o_waddr,
        input  o_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot-time framed program loader into instruction memory
module prog_loader #(
    parameter int         AWIDTH    = 8,
    parameter int         BASE_ADDR = 0,
    parameter logic [7:0] MAGIC     = 8'hA5,
    parameter int         TIMEOUT   = 1000
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.master bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);
    // Idle counter holds 0..TIMEOUT-1; the TIMEOUT-th idle cycle aborts.
    localparam int                CW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0]     IDLE_LAST = CW'(TIMEOUT - 1);
    localparam logic [AWIDTH-1:0] BASE      = AWIDTH'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state;
    logic [7:0]    len;
    logic [7:0]    hi_byte;
    logic [7:0]    sum;
    logic [7:0]    word_idx;
    logic [CW-1:0] idle_cnt;

    logic       xfer;
    logic       counting;
    logic       timed_out;
    logic [7:0] word_next;

    assign xfer      = bus.rx_valid & bus.rx_ready;
    assign counting  = (state == S_LEN) || (state == S_HI) ||
                       (state == S_LO)  || (state == S_CSUM);
    assign timed_out = counting && !xfer && (idle_cnt == IDLE_LAST);
    assign word_next = word_idx + 8'd1;

    // Frame parser, write strobe generation and status outputs, all registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            len          <= '0;
            hi_byte      <= '0;
            sum          <= '0;
            word_idx     <= '0;
            idle_cnt     <= '0;
            bus.rx_ready <= 1'b0;
            bus.o_wr     <= 1'b0;
            bus.o_waddr  <= BASE;
            bus.o_wdata  <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            bus.o_wr     <= 1'b0;
            bus.rx_ready <= 1'b1;

            // Counter is cleared outside frame states so every entry starts from zero
            if (!counting || xfer) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + CW'(1);
            end

            if (timed_out) begin
                state <= S_ERR;
                err   <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (xfer && bus.rx_data == MAGIC) begin
                            state <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (xfer) begin
                            len      <= bus.rx_data;
                            sum      <= '0;
                            word_idx <= '0;
                            state    <= (bus.rx_data == 8'd0) ? S_CSUM : S_HI;
                        end
                    end
                    S_HI: begin
                        if (xfer) begin
                            hi_byte <= bus.rx_data;
                            sum     <= sum + bus.rx_data;
                            state   <= S_LO;
                        end
                    end
                    S_LO: begin
                        if (xfer) begin
                            sum          <= sum + bus.rx_data;
                            bus.o_wr     <= 1'b1;
                            bus.o_wdata  <= {hi_byte, bus.rx_data};
                            bus.o_waddr  <= BASE + AWIDTH'(word_idx);
                            bus.rx_ready <= 1'b0;
                            state        <= S_WRITE;
                        end
                    end
                    S_WRITE: begin
                        word_idx <= word_next;
                        state    <= (word_next == len) ? S_CSUM : S_HI;
                    end
                    S_CSUM: begin
                        if (xfer) begin
                            if (bus.rx_data == sum) begin
                                state        <= S_DONE;
                                done         <= 1'b1;
                                cpu_hold     <= 1'b0;
                                bus.rx_ready <= 1'b0;
                            end else begin
                                state <= S_ERR;
                                err   <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        bus.rx_ready <= 1'b0;
                    end
                    S_ERR: begin
                        if (xfer && bus.rx_data == MAGIC) begin
                            err   <= 1'b0;
                            state <= S_LEN;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader
module tb_prog_loader;
    localparam int         AW     = 8;
    localparam int         TMO    = 1000;
    localparam logic [7:0] MAGIC  = 8'hA5;
    localparam logic [7:0] BASE_B = 8'hFE;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;

    logic hold_a, done_a, err_a;
    logic hold_b, done_b, err_b;

    always #5 clk = ~clk;

    prog_loader_if #(.AWIDTH(AW)) bus_a ();
    prog_loader_if #(.AWIDTH(AW)) bus_b ();

    assign bus_a.rx_data  = rx_data;
    assign bus_a.rx_valid = rx_valid;
    assign bus_b.rx_data  = rx_data;
    assign bus_b.rx_valid = rx_valid;

    prog_loader #(.AWIDTH(AW), .BASE_ADDR(0), .MAGIC(MAGIC), .TIMEOUT(TMO)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_a),
        .cpu_hold (hold_a),
        .done     (done_a),
        .err      (err_a)
    );

    prog_loader #(.AWIDTH(AW), .BASE_ADDR(254), .MAGIC(MAGIC), .TIMEOUT(TMO)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_b),
        .cpu_hold (hold_b),
        .done     (done_b),
        .err      (err_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [23:0] got_a[$];
    logic [23:0] got_b[$];
    logic [15:0] exp_words[$];
    logic        exp_ok;
    logic [7:0]  fr[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Capture every write strobe; the loader must not accept bytes while writing
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_a.o_wr) begin
                got_a.push_back({bus_a.o_waddr, bus_a.o_wdata});
                check_eq("ready_in_write_a", 32'(bus_a.rx_ready), 32'd0);
            end
            if (bus_b.o_wr) begin
                got_b.push_back({bus_b.o_waddr, bus_b.o_wdata});
                check_eq("ready_in_write_b", 32'(bus_b.rx_ready), 32'd0);
            end
        end
    end

    // Reference: skip to MAGIC, read LEN words, compare byte sum with CSUM
    task automatic model(input logic [7:0] fb[$]);
        int p;
        int n;
        int s;
        p = 0;
        s = 0;
        exp_words.delete();
        while (p < fb.size() && fb[p] != MAGIC) p++;
        p++;
        n = int'(fb[p]);
        p++;
        for (int i = 0; i < n; i++) begin
            exp_words.push_back({fb[p], fb[p+1]});
            s = s + int'(fb[p]) + int'(fb[p+1]);
            p += 2;
        end
        exp_ok = (int'(fb[p]) == (s % 256));
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        waited = 0;
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        while (!bus_a.rx_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus_a.rx_ready) check_eq("ready_stall", 32'(bus_a.rx_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_bytes(input logic [7:0] fb[$], input int maxgap);
        foreach (fb[i]) send_byte(fb[i], $urandom_range(0, maxgap));
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic verify(input string tag);
        logic [7:0] ea;
        check_eq({tag, "_nwr_a"}, 32'(got_a.size()), 32'(exp_words.size()));
        check_eq({tag, "_nwr_b"}, 32'(got_b.size()), 32'(exp_words.size()));
        for (int i = 0; i < exp_words.size() && i < got_a.size(); i++)
            check_eq({tag, "_wr_a"}, 32'(got_a[i]), {8'd0, 8'(i), exp_words[i]});
        for (int i = 0; i < exp_words.size() && i < got_b.size(); i++) begin
            ea = BASE_B + 8'(i);
            check_eq({tag, "_wr_b"}, 32'(got_b[i]), {8'd0, ea, exp_words[i]});
        end
        check_eq({tag, "_done_a"}, 32'(done_a), 32'(exp_ok));
        check_eq({tag, "_err_a"},  32'(err_a),  32'(!exp_ok));
        check_eq({tag, "_hold_a"}, 32'(hold_a), 32'(!exp_ok));
        check_eq({tag, "_done_b"}, 32'(done_b), 32'(exp_ok));
        check_eq({tag, "_err_b"},  32'(err_b),  32'(!exp_ok));
        check_eq({tag, "_hold_b"}, 32'(hold_b), 32'(!exp_ok));
        got_a.delete();
        got_b.delete();
    endtask

    task automatic run_frame(input string tag, input logic [7:0] fb[$], input int maxgap);
        model(fb);
        send_bytes(fb, maxgap);
        verify(tag);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_eq("rst_ready_a", 32'(bus_a.rx_ready), 32'd0);
        check_eq("rst_wr_a",    32'(bus_a.o_wr),     32'd0);
        check_eq("rst_addr_a",  32'(bus_a.o_waddr),  32'd0);
        check_eq("rst_addr_b",  32'(bus_b.o_waddr),  32'(BASE_B));
        check_eq("rst_data_a",  32'(bus_a.o_wdata),  32'd0);
        check_eq("rst_hold_a",  32'(hold_a),         32'd1);
        check_eq("rst_done_a",  32'(done_a),         32'd0);
        check_eq("rst_err_a",   32'(err_a),          32'd0);
        check_eq("rst_hold_b",  32'(hold_b),         32'd1);
        got_a.delete();
        got_b.delete();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic build_random();
        int         njunk;
        int         n;
        logic [7:0] b;
        logic [7:0] s;
        fr.delete();
        njunk = $urandom_range(0, 3);
        for (int i = 0; i < njunk; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == MAGIC) b = 8'h00;
            fr.push_back(b);
        end
        fr.push_back(MAGIC);
        n = $urandom_range(0, 6);
        fr.push_back(8'(n));
        s = 8'h00;
        for (int i = 0; i < 2 * n; i++) begin
            b = 8'($urandom_range(0, 255));
            s = s + b;
            fr.push_back(b);
        end
        if ($urandom_range(0, 2) == 0) s = s ^ 8'($urandom_range(1, 255));
        fr.push_back(s);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        do_reset();
        run_frame("single", '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h46}, 0);

        do_reset();
        run_frame("three", '{8'hA5, 8'h03, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'h80, 8'h00, 8'h7F}, 0);

        do_reset();
        run_frame("badsum", '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h47}, 0);
        run_frame("recover", '{8'hA5, 8'h01, 8'hAB, 8'hCD, 8'h78}, 1);

        do_reset();
        run_frame("junk_len0", '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00}, 0);

        do_reset();
        send_bytes('{8'hA5, 8'h02, 8'h12}, 0);
        repeat (TMO - 6) @(negedge clk);
        check_eq("tmo_early_err", 32'(err_a), 32'd0);
        repeat (10) @(negedge clk);
        check_eq("tmo_err_a",  32'(err_a),        32'd1);
        check_eq("tmo_hold_a", 32'(hold_a),       32'd1);
        check_eq("tmo_done_a", 32'(done_a),       32'd0);
        check_eq("tmo_err_b",  32'(err_b),        32'd1);
        check_eq("tmo_nwr",    32'(got_a.size()), 32'd0);

        do_reset();
        send_bytes('{8'hA5, 8'h02, 8'h12, 8'h34}, 1);
        check_eq("mid_nwr", 32'(got_a.size()), 32'd1);
        do_reset();
        run_frame("after_rst", '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h46}, 2);

        for (int it = 0; it < 40; it++) begin
            if (exp_ok) do_reset();
            build_random();
            run_frame("rand", fr, 2);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader: receives a framed byte stream and writes 16-bit instruction words into the instruction ROM's write port. It is the writer to the ROM the CPU core reads.
- Holds the CPU core in reset (cpu_hold) until a frame has loaded and its checksum passes.
- Frame format: MAGIC, LEN (word count), 2*LEN data bytes (high byte first), CSUM. CSUM is the 8-bit sum modulo 256 of all data bytes.

Parameters:
- AWIDTH, 8, instruction-memory address width; must be ≥ 8 so LEN=255 fits.
- BASE_ADDR, 0, address of the first loaded word.
- MAGIC, 8'hA5, frame start byte.
- TIMEOUT, 1000, idle cycles allowed between bytes inside a frame before abort; ≥ 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts the byte; transfer occurs when rx_valid & rx_ready at a rising edge.
- o_wr  out  1  single-cycle write strobe to the instruction memory.
- o_waddr  out  AWIDTH  write address.
- o_wdata  out  16  write data.
- cpu_hold  out  1  held high to keep the core in reset.
- done  out  1  load completed successfully (sticky).
- err  out  1  last frame aborted (checksum or timeout).

Behaviour:
- Reset values: rx_ready=0, o_wr=0, o_waddr=BASE_ADDR, o_wdata=0, cpu_hold=1, done=0, err=0, state=IDLE, counters cleared. Reset mid-frame discards all progress; writes already issued are not undone.
- States: IDLE, LEN, HI, LO, WRITE, CSUM, DONE, ERR.
- rx_ready is 1 in IDLE, LEN, HI, LO, CSUM and ERR. It is 0 in WRITE and DONE, and on the cycle out of reset.
- IDLE: an accepted byte equal to MAGIC goes to LEN; any other byte is dropped and the state stays IDLE.
- LEN: latch the word count and clear the sum. LEN=0 goes directly to CSUM (expected CSUM 0x00); otherwise go to HI.
- HI: latch the high byte, add it to the sum, go to LO.
- LO: latch the low byte, add it to the sum, go to WRITE.
- WRITE (one cycle): o_wr=1, o_wdata={hi,lo}, o_waddr=BASE_ADDR+word_index. Addition wraps modulo 2^AWIDTH.
  - Write latency: o_wr asserts the cycle after the LO byte is accepted.
  - After the write, word_index increments. If word_index = LEN, go to CSUM; else go to HI.
- CSUM: accepted byte equal to the sum goes to DONE; a mismatch goes to ERR.
- DONE: cpu_hold=0 and done=1 from the cycle after CSUM is accepted. The state stays DONE until rst; all input is ignored.
- ERR: err=1 and cpu_hold=1. A MAGIC byte clears err and goes to LEN; other bytes are dropped.
- Timeout: an idle counter runs in LEN, HI, LO and CSUM.
  - It resets on each accepted byte and on each entry to these states.
  - Reaching TIMEOUT cycles without a transfer goes to ERR.
  - The counter does not run in IDLE, ERR or DONE.
- The sum is 8 bits and wraps modulo 256.
- A MAGIC value appearing inside a frame is treated as data; there is no resync.
- o_waddr and o_wdata hold their last values when o_wr=0.
- Only one byte can be accepted per cycle.
- Backpressure: rx_ready drops during WRITE, so the peak rate is 2 bytes per 3 cycles.

Test Plan:
- Reset, then frame A5,01,12,34,46 with rx_valid held high: exactly one o_wr pulse with o_waddr=0x00, o_wdata=0x1234; then done=1, cpu_hold=0, err=0.
- Frame A5,03 with words 0x0001, 0xFFFF, 0x8000, CSUM 0x7F: three writes at addresses 0,1,2 in order; done=1.
- Same as case 1 but CSUM 0x47: err=1, cpu_hold=1, done=0. Then send a valid frame A5,01,AB,CD,78: err clears and done=1.
- Junk bytes 00,FF,5A before A5,00,00: junk is ignored, no o_wr pulses, done=1.
- A5,02,12 then rx_valid low for TIMEOUT cycles: err=1 with no write issued. Apply rst mid-frame during a separate load: all outputs return to their reset values.
- BASE_ADDR=0xFE, LEN=3: writes go to 0xFE, 0xFF, 0x00 (wrap). rx_ready is low on every WRITE cycle.
